// File: rtl/nvm_pkg.sv
// Shared NVM definitions for the reader and writer paths.
// Holds writer FSM state encoding and default bus widths.
package nvm_pkg;

  localparam int NVM_DATA_W = 8;
  localparam int NVM_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE
  } nvm_wr_state_t;

endpackage

// File: rtl/nvm_writer_if.sv
// NVM write port: we/addr/wdata from writer, ready from array.
// master = writer side, slave = NVM array side.
interface nvm_writer_if
  import nvm_pkg::*;
#(
  parameter int DATA_W = NVM_DATA_W,
  parameter int ADDR_W = NVM_ADDR_W
);

  logic              nvm_we;
  logic              nvm_ready;
  logic [ADDR_W-1:0] nvm_addr;
  logic [DATA_W-1:0] nvm_wdata;

  modport master (
    output nvm_we,
    output nvm_addr,
    output nvm_wdata,
    input  nvm_ready
  );

  modport slave (
    input  nvm_we,
    input  nvm_addr,
    input  nvm_wdata,
    output nvm_ready
  );

endinterface

// File: rtl/sipo_reg.sv
// Serial-in parallel-out register, bit order set by MSB_FIRST.
// Ports: clk, rst, clr, shift, serial_in -> data_out.
module sipo_reg #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (shift) begin
      if (MSB_FIRST)
        q <= {q[DATA_W-2:0], serial_in};
      else
        q <= {serial_in, q[DATA_W-1:1]};
    end
  end

  assign data_out = q;

endmodule

// File: rtl/nvm_writer.sv
// Deserializes a serial word and issues one NVM write.
// Ports: clk, rst, wr_start/address_in, bit_valid/serial_in, abort, nvm (master), busy, done, ovr.
module nvm_writer
  import nvm_pkg::*;
#(
  parameter int DATA_W    = NVM_DATA_W,
  parameter int ADDR_W    = NVM_ADDR_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              bit_valid,
  input  logic              serial_in,
  input  logic              abort,
  nvm_writer_if.master      nvm,
  output logic              busy,
  output logic              done,
  output logic              ovr
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  nvm_wr_state_t     state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, we_d;
  logic              done_d, ovr_d;
  logic              shift, clr, load;
  logic [DATA_W-1:0] word;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    shift   = 1'b0;
    clr     = 1'b0;
    load    = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          load    = 1'b1;
          clr     = 1'b1;
        end
      end
      SHIFT: begin
        // abort beats a coincident final bit
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bit_valid) begin
          shift = 1'b1;
          cnt_d = cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state_d = WRITE;
            we_d    = 1'b1;
          end
        end
      end
      WRITE: begin
        // late bits are dropped, only flagged
        ovr_d = bit_valid;
        if (nvm.nvm_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          we_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      done   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      we_q  <= we_d;
      done  <= done_d;
      ovr   <= ovr_d;
      if (load)
        addr_q <= address_in;
    end
  end

  sipo_reg #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift    (shift),
    .serial_in(serial_in),
    .data_out (word)
  );

  assign nvm.nvm_we    = we_q;
  assign nvm.nvm_addr  = addr_q;
  assign nvm.nvm_wdata = word;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_nvm_writer.sv
// Bench for nvm_writer: MSB-first and LSB-first instances
// driven in parallel, writes checked against a scoreboard.
module tb_nvm_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_start;
  logic [7:0] address_in;
  logic       bit_valid;
  logic       serial_in;
  logic       abort;
  logic       ready;
  logic       busy0, done0, ovr0;
  logic       busy1, done1, ovr1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] s;
    int         gap;
    int         stall;
    bit         misuse;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] m;
    logic [7:0] l;
  } exp_t;

  exp_t sb[$];
  vec_t vt[5];

  nvm_writer_if n0 ();
  nvm_writer_if n1 ();

  assign n0.nvm_ready = ready;
  assign n1.nvm_ready = ready;

  always #5 clk = ~clk;

  nvm_writer #(.MSB_FIRST(1'b1)) u0 (
    .clk       (clk),
    .rst       (rst),
    .wr_start  (wr_start),
    .address_in(address_in),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .abort     (abort),
    .nvm       (n0.master),
    .busy      (busy0),
    .done      (done0),
    .ovr       (ovr0)
  );

  nvm_writer #(.MSB_FIRST(1'b0)) u1 (
    .clk       (clk),
    .rst       (rst),
    .wr_start  (wr_start),
    .address_in(address_in),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .abort     (abort),
    .nvm       (n1.master),
    .busy      (busy1),
    .done      (done1),
    .ovr       (ovr1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // done implies acceptance in the previous cycle;
  // addr/wdata still hold the written values here
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_addr", n0.nvm_addr, e.a);
        chk("sb_wdata_msb", n0.nvm_wdata, e.m);
        chk("sb_wdata_lsb", n1.nvm_wdata, e.l);
        chk("sb_done_lsb", done1, 1);
      end
    end
  end

  task automatic run_tx(input vec_t v);
    int  wc;
    int  oc;
    bit  fin;
    sb.push_back('{v.addr, v.exp_m, v.exp_l});
    wr_start   = 1'b1;
    address_in = v.addr;
    ready      = 1'b0;
    @(negedge clk);
    wr_start   = 1'b0;
    address_in = 8'($urandom);
    chk("busy_shift", busy0, 1);
    for (int i = 0; i < 8; i++) begin
      if (v.misuse && i == 3) begin
        wr_start   = 1'b1;
        address_in = 8'h77;
        @(negedge clk);
        wr_start = 1'b0;
      end
      bit_valid = 1'b1;
      serial_in = v.s[7-i];
      @(negedge clk);
      bit_valid = 1'b0;
      if (i < 7)
        repeat (v.gap) @(negedge clk);
    end
    wc  = 0;
    oc  = 0;
    fin = 1'b0;
    for (int k = 0; k < 64 && !fin; k++) begin
      if (ovr0) oc++;
      if (n0.nvm_we) begin
        wc++;
        chk("hold_addr", n0.nvm_addr, v.addr);
        chk("hold_wdata", n0.nvm_wdata, v.exp_m);
        ready     = (wc > v.stall);
        bit_valid = v.misuse && (wc == 1);
        serial_in = 1'b1;
        @(negedge clk);
      end else begin
        fin       = 1'b1;
        bit_valid = 1'b0;
        ready     = 1'b0;
        chk("done_pulse", done0, 1);
      end
    end
    if (!fin) chk("write_timeout", 0, 1);
    chk("we_cycles", wc, v.stall + 1);
    chk("ovr_count", oc, v.misuse ? 1 : 0);
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_done", done0, 0);
    chk("idle_busy", busy0, 0);
    chk("idle_we", n0.nvm_we, 0);
  endtask

  task automatic send_bits(input logic [7:0] s,
                           input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      serial_in = s[7-i];
      @(negedge clk);
    end
    bit_valid = 1'b0;
  endtask

  task automatic zero_check(input string nm);
    chk({nm, "_we"}, n0.nvm_we, 0);
    chk({nm, "_addr"}, n0.nvm_addr, 0);
    chk({nm, "_wdata"}, n0.nvm_wdata, 0);
    chk({nm, "_wdata_lsb"}, n1.nvm_wdata, 0);
    chk({nm, "_busy"}, busy0, 0);
    chk({nm, "_done"}, done0, 0);
    chk({nm, "_ovr"}, ovr0, 0);
  endtask

  initial begin
    vt[0] = '{8'h3C, 8'hA5, 0, 0, 1'b0, 8'hA5, 8'hA5};
    vt[1] = '{8'h42, 8'h5A, 2, 3, 1'b0, 8'h5A, 8'h5A};
    vt[2] = '{8'h01, 8'hC0, 0, 0, 1'b0, 8'hC0, 8'h03};
    vt[3] = '{8'h21, 8'h96, 1, 2, 1'b1, 8'h96, 8'h69};
    vt[4] = '{8'hFE, 8'h01, 0, 1, 1'b0, 8'h01, 8'h80};

    rst        = 1'b1;
    wr_start   = 1'b0;
    address_in = 8'h00;
    bit_valid  = 1'b0;
    serial_in  = 1'b0;
    abort      = 1'b0;
    ready      = 1'b0;
    repeat (3) @(negedge clk);
    zero_check("reset");
    rst = 1'b0;
    @(negedge clk);

    // entry 4 starts in the done cycle of entry 3
    for (int t = 0; t < 5; t++) begin
      run_tx(vt[t]);
      if (t != 3) idle_check();
    end

    // abort after 4 bits
    wr_start   = 1'b1;
    address_in = 8'h55;
    @(negedge clk);
    wr_start = 1'b0;
    send_bits(8'hB3, 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_we", n0.nvm_we, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_done", done0, 0);
    run_tx('{8'h10, 8'hFF, 0, 0, 1'b0, 8'hFF, 8'hFF});
    idle_check();

    // abort coincident with the final bit
    wr_start   = 1'b1;
    address_in = 8'h33;
    @(negedge clk);
    wr_start = 1'b0;
    send_bits(8'hFF, 7);
    bit_valid = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    abort     = 1'b0;
    chk("abort_last_busy", busy0, 0);
    chk("abort_last_we", n0.nvm_we, 0);
    @(negedge clk);
    chk("abort_last_done", done0, 0);

    // reset in SHIFT after 5 bits
    wr_start   = 1'b1;
    address_in = 8'h66;
    @(negedge clk);
    wr_start = 1'b0;
    send_bits(8'hF8, 5);
    rst = 1'b1;
    @(negedge clk);
    zero_check("rst_shift");
    rst = 1'b0;
    @(negedge clk);

    // reset in WRITE with the NVM stalled
    wr_start   = 1'b1;
    address_in = 8'h99;
    @(negedge clk);
    wr_start = 1'b0;
    send_bits(8'hFF, 8);
    chk("rst_write_pre_we", n0.nvm_we, 1);
    rst = 1'b1;
    @(negedge clk);
    zero_check("rst_write");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_write_no_done", done0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nvm_writer.md
Name: nvm_writer

Overview:
- Write-side counterpart of the NVM read path.
- Receives a serial bit stream, deserializes it into a DATA_W-bit word, and issues one write to the NVM.
- The write is presented on a parallel address/data port with a ready handshake.
- Sits between the serial host link and the NVM array port, alongside the reader.

Parameters:
- DATA_W, 8, serial word length and NVM data width.
- ADDR_W, 8, NVM address width.
- MSB_FIRST, 1, 1 = first received bit lands in bit DATA_W-1; 0 = first bit lands in bit 0.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_start  input  1  start of a write transaction; sampled in IDLE only.
- address_in  input  ADDR_W  target address; captured in the wr_start cycle.
- bit_valid  input  1  qualifies serial_in this cycle.
- serial_in  input  1  serial data bit.
- abort  input  1  cancels a transaction in SHIFT.
- nvm_ready  input  1  NVM accepts the write in a cycle where nvm_we=1.
- nvm_we  output  1  write request to NVM; held until accepted.
- nvm_addr  output  ADDR_W  write address, stable while nvm_we=1.
- nvm_wdata  output  DATA_W  write data, stable while nvm_we=1.
- busy  output  1  high in SHIFT and WRITE.
- done  output  1  one-cycle pulse after the write is accepted.
- ovr  output  1  one-cycle pulse when bit_valid=1 arrives in WRITE.

Behaviour:
- Reset: rst=1 at a clock edge forces IDLE. All outputs go to 0, the bit counter clears, and the shift register clears. This holds from any state. A transaction in progress is dropped with no nvm_we and no done.
- States: IDLE, SHIFT, WRITE. Encoded in a registered enum. Outputs nvm_we, nvm_addr, nvm_wdata, done and ovr are registered.
- IDLE → SHIFT: on wr_start=1. address_in is latched into the address register and the counter is set to 0. serial_in is not sampled in this cycle. bit_valid in IDLE is ignored.
- SHIFT, bit capture: each cycle with bit_valid=1 shifts serial_in in (direction per MSB_FIRST) and increments the counter. Cycles with bit_valid=0 hold state; gaps are unlimited.
- SHIFT → WRITE: on the cycle the DATA_W-th valid bit is taken. From the next cycle, nvm_we=1, nvm_addr = latched address and nvm_wdata = assembled word.
- SHIFT, abort: abort=1 returns to IDLE with no write, no done and the counter cleared. If abort and the final bit_valid occur in the same cycle, abort wins.
- WRITE: nvm_we stays high and addr/data stay stable until a cycle with nvm_ready=1. In the next cycle nvm_we=0, done=1 for exactly one cycle, and the state is IDLE.
  - Minimum accept latency: nvm_we rises the cycle after the last bit. With nvm_ready tied high, done follows one cycle later.
  - abort is ignored in WRITE; a presented write always completes.
- wr_start while busy is ignored. address_in changes after capture have no effect.
- ovr: bit_valid=1 in WRITE pulses ovr the next cycle. The bit is discarded; the word is unaffected.
- wr_start in the done cycle: accepted, since the state is already IDLE. Back-to-back transactions are therefore possible with one idle cycle between words.
- nvm_addr and nvm_wdata keep their last values after the write. Their value is meaningful only while nvm_we=1.

Decomposition:
- nvm_pkg holds:
  - state enum nvm_wr_state_t {IDLE, SHIFT, WRITE};
  - default width constants NVM_DATA_W=8 and NVM_ADDR_W=8, shared with the reader.
- Sub-module sipo_reg: parameterized DATA_W serial-in parallel-out register with inputs clk, rst, clr, shift, serial_in, output data_out, and parameter MSB_FIRST. It mirrors the reader's PISO.
- The FSM, counter and handshake live in nvm_writer.

Test Plan:
- Basic write: wr_start with address_in=0x3C; bits 1,0,1,0,0,1,0,1 on 8 consecutive bit_valid cycles; nvm_ready=1. Expect nvm_we high for exactly 1 cycle with nvm_addr=0x3C and nvm_wdata=0xA5, then done pulses for 1 cycle and busy drops.
- Gapped bits + stalled NVM: 0x5A sent with bit_valid low 2 cycles between each bit; nvm_ready low for 3 cycles. Expect nvm_we held 4 cycles with stable addr/data, done once, nvm_wdata=0x5A.
- Bit order: MSB_FIRST=0, same bits as the basic write. Expect nvm_wdata=0xA5 bit-reversed = 0xA5 (palindrome). Repeat with bits 1,1,0,0,0,0,0,0: MSB_FIRST=1 gives 0xC0, MSB_FIRST=0 gives 0x03.
- Abort: abort after 4 bits. Expect no nvm_we, no done, busy=0 next cycle. A following transaction to 0x10 with 0xFF writes 0xFF with no residue.
- Reset mid-operation: rst=1 in SHIFT after 5 bits, and again in WRITE while nvm_ready=0. Both cases give all outputs 0 next cycle, no done, and the state is IDLE.
- Protocol misuse: wr_start and address_in=0x77 pulsed during SHIFT, and bit_valid asserted in WRITE. Expect the address to stay at its original value, ovr to pulse once, and nvm_wdata to be unchanged.
